// File: rtl/jk_ff_bank_if.sv
// Bus interface for jk_ff_bank: control, per-channel data and status outputs.
// The master modport drives the controls; the slave modport is the flip-flop bank.
interface jk_ff_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             illegal_clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_bar;
   logic             illegal;
   logic             changed;
   logic [CNT_W-1:0] change_cnt;

   modport master (
      output en, mode, j, k, load, load_data, illegal_clr,
      input  q, q_bar, illegal, changed, change_cnt
   );

   modport slave (
      input  en, mode, j, k, load, load_data, illegal_clr,
      output q, q_bar, illegal, changed, change_cnt
   );
endinterface

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH independent flip-flops with a shared run-time mode
// (JK / D / T / SR), parallel load, global enable, complementary outputs,
// sticky illegal-SR flag and a registered change pulse.
// Optional macro JK_FF_BANK_CHANGE_CNT_EN adds a saturating change-event
// counter; without it change_cnt is tied to zero.
module jk_ff_bank #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
   parameter int                 CNT_W   = 16
) (
   input  logic          clk,
   input  logic          rst,
   jk_ff_bank_if.slave   bus
);

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_D  = 2'b01;
   localparam logic [1:0] MODE_T  = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_bar_q;
   logic [WIDTH-1:0] q_bar_d;
   logic             illegal_q;
   logic             illegal_d;
   logic             changed_q;
   logic             changed_d;
   logic [WIDTH-1:0] upd_s;
   logic             sr_conflict_s;

   // Per-channel characteristic equation for the currently selected mode.
   always_comb begin
      upd_s = q_q;
      case (bus.mode)
         MODE_JK: upd_s = (bus.j & ~q_q) | (~bus.k & q_q);
         MODE_D:  upd_s = bus.j;
         MODE_T:  upd_s = q_q ^ bus.j;
         MODE_SR: upd_s = (bus.j & ~bus.k) | (q_q & ~(~bus.j & bus.k));
         default: upd_s = q_q;
      endcase
   end

   // Next state of q with priority rst > load > en; q_bar tracks ~q_d so both flops agree every cycle.
   always_comb begin
      q_d = q_q;
      if (rst) begin
         q_d = RST_VAL;
      end else if (bus.load) begin
         q_d = bus.load_data;
      end else if (bus.en) begin
         q_d = upd_s;
      end else begin
         q_d = q_q;
      end
      q_bar_d = ~q_d;
   end

   // Sticky illegal flag: an enabled SR edge with S=R=1 on any channel sets it, and set beats clear.
   always_comb begin
      sr_conflict_s = (bus.mode == MODE_SR) && bus.en && !bus.load && (|(bus.j & bus.k));
      illegal_d     = illegal_q;
      if (rst) begin
         illegal_d = 1'b0;
      end else if (sr_conflict_s) begin
         illegal_d = 1'b1;
      end else if (bus.illegal_clr) begin
         illegal_d = 1'b0;
      end else begin
         illegal_d = illegal_q;
      end
   end

   // Change pulse: high for the cycle after any non-reset edge that altered q.
   always_comb begin
      changed_d = 1'b0;
      if (rst) begin
         changed_d = 1'b0;
      end else begin
         changed_d = (q_d != q_q);
      end
   end

   // State registers with synchronous reset folded into the _d logic above.
   always_ff @(posedge clk) begin
      q_q       <= q_d;
      q_bar_q   <= q_bar_d;
      illegal_q <= illegal_d;
      changed_q <= changed_d;
   end

   assign bus.q       = q_q;
   assign bus.q_bar   = q_bar_q;
   assign bus.illegal = illegal_q;
   assign bus.changed = changed_q;

`ifdef JK_FF_BANK_CHANGE_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturating count of edges that raise the change pulse; only reset clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (rst) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (changed_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Change-event counter register.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign bus.change_cnt = cnt_q;
`else
   assign bus.change_cnt = {CNT_W{1'b0}};
`endif

endmodule
